// File: rtl/gpio_filter_pkg.sv
// Shared constants, per-pin output bundle and counter sizing for the GPIO input filter.
package gpio_filter_pkg;

    localparam int unsigned GPIO_FILTER_DEFAULT_SAMPLES    = 4;
    localparam int unsigned GPIO_FILTER_DEFAULT_PRESCALE_W = 16;

    typedef struct packed {
        logic filtered;
        logic rise;
        logic fall;
    } pin_out_t;

    // ceil(log2(samples)), never below 1 so SAMPLES of 1 or 2 still gets a real register
    function automatic int unsigned gpio_filter_cnt_w(input int unsigned samples);
        return (samples <= 2) ? 1 : $clog2(samples);
    endfunction

endpackage

// File: rtl/gpio_filter_pin.sv
// Single-pin conditioner: two-flop synchroniser, tick-gated debounce counter, filtered bit
// and, when GPIO_FILTER_EDGE_EN is defined, registered rise/fall pulses.
module gpio_filter_pin
    import gpio_filter_pkg::*;
#(
    parameter int unsigned SAMPLES = GPIO_FILTER_DEFAULT_SAMPLES
)(
    input  logic     io_clock,
    input  logic     io_reset,
    input  logic     i_raw,
    input  logic     i_tick,
    input  logic     i_bypass,
    output pin_out_t o_pin
);

    localparam int unsigned        CNT_W    = gpio_filter_cnt_w(SAMPLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SAMPLES - 1);

    logic             r_ff1;
    logic             r_sync;
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_filt_next;
    logic [CNT_W-1:0] w_cnt_next;

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            r_ff1  <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_ff1  <= i_raw;
            r_sync <= r_ff1;
        end
    end

    // Any matching tick clears the count, so only an unbroken run of SAMPLES mismatches is accepted
    always_comb begin
        w_filt_next = r_filt;
        w_cnt_next  = r_cnt;
        if (i_bypass) begin
            w_filt_next = r_sync;
            w_cnt_next  = '0;
        end else if (i_tick) begin
            if (r_sync == r_filt) begin
                w_cnt_next = '0;
            end else if (r_cnt == CNT_LAST) begin
                w_filt_next = r_sync;
                w_cnt_next  = '0;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_filt <= w_filt_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign o_pin.filtered = r_filt;

`ifdef GPIO_FILTER_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Edges are taken from the next filtered value so the pulse lines up with the new level
    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_filt_next & ~r_filt;
            r_fall <= ~w_filt_next & r_filt;
        end
    end

    assign o_pin.rise = r_rise;
    assign o_pin.fall = r_fall;
`else
    assign o_pin.rise = 1'b0;
    assign o_pin.fall = 1'b0;
`endif

endmodule

// File: rtl/gpio_input_filter.sv
// GPIO input conditioner: shared sample-tick prescaler plus WIDTH independent debounced pins.
// Rise/fall pulse generation is built only when GPIO_FILTER_EDGE_EN is defined.
module gpio_input_filter
    import gpio_filter_pkg::*;
#(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned PRESCALE_W = GPIO_FILTER_DEFAULT_PRESCALE_W,
    parameter int unsigned SAMPLES    = GPIO_FILTER_DEFAULT_SAMPLES
)(
    input  logic                  io_clock,
    input  logic                  io_reset,
    input  logic [WIDTH-1:0]      io_pins_raw,
    input  logic [PRESCALE_W-1:0] io_cfg_prescale,
    input  logic                  io_cfg_bypass,
    output logic [WIDTH-1:0]      io_pins_filtered,
    output logic [WIDTH-1:0]      io_rise,
    output logic [WIDTH-1:0]      io_fall
);

    logic [PRESCALE_W-1:0] r_presc_cnt;
    logic                  w_tick;
    pin_out_t              w_pin_out [WIDTH];

    // >= rather than == so a lowered prescale ticks at once instead of wrapping the counter
    assign w_tick = (r_presc_cnt >= io_cfg_prescale);

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            r_presc_cnt <= '0;
        end else if (w_tick) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + PRESCALE_W'(1);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        gpio_filter_pin #(
            .SAMPLES (SAMPLES)
        ) u_pin (
            .io_clock (io_clock),
            .io_reset (io_reset),
            .i_raw    (io_pins_raw[g]),
            .i_tick   (w_tick),
            .i_bypass (io_cfg_bypass),
            .o_pin    (w_pin_out[g])
        );

        assign io_pins_filtered[g] = w_pin_out[g].filtered;
        assign io_rise[g]          = w_pin_out[g].rise;
        assign io_fall[g]          = w_pin_out[g].fall;
    end

endmodule

// File: tb/tb_gpio_input_filter.sv
// Self-checking bench for gpio_input_filter (WIDTH=8, SAMPLES=4); edge expectations follow GPIO_FILTER_EDGE_EN.
module tb_gpio_input_filter;

`ifdef GPIO_FILTER_EDGE_EN
    localparam logic [7:0] EM = 8'hFF;
`else
    localparam logic [7:0] EM = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        io_reset;
    logic [7:0]  io_pins_raw;
    logic [15:0] io_cfg_prescale;
    logic        io_cfg_bypass;
    logic [7:0]  io_pins_filtered;
    logic [7:0]  io_rise;
    logic [7:0]  io_fall;

    gpio_input_filter #(
        .WIDTH      (8),
        .PRESCALE_W (16),
        .SAMPLES    (4)
    ) dut (
        .io_clock         (clk),
        .io_reset         (io_reset),
        .io_pins_raw      (io_pins_raw),
        .io_cfg_prescale  (io_cfg_prescale),
        .io_cfg_bypass    (io_cfg_bypass),
        .io_pins_filtered (io_pins_filtered),
        .io_rise          (io_rise),
        .io_fall          (io_fall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] raw;
        logic [7:0] f;
        logic [7:0] r;
        logic [7:0] fl;
    } vec_t;

    typedef struct {
        int         at;
        logic [7:0] f;
        logic [7:0] r;
        logic [7:0] fl;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expect_at(input int at, input logic [7:0] f, input logic [7:0] r,
                             input logic [7:0] fl, input string name);
        sb.push_back('{at, f, r, fl, name});
    endtask

    // Advance to the next falling edge(s), retiring any scoreboard entries due on that cycle
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    check($sformatf("%s@+%0d", sb[i].name, cyc),
                          {8'h00, io_pins_filtered, io_rise, io_fall},
                          {8'h00, sb[i].f, sb[i].r, sb[i].fl});
                    sb.delete(i);
                end
            end
        end
    endtask

    vec_t tbl[10];
    int   c;
    int   first;
    int   nrise;
    bit   seen;
    bit   rise_at_first;
    int   nt;
    logic pat[6];

    initial begin
        tbl[0] = '{8'h21, 8'h21, 8'h20, 8'h00};
        tbl[1] = '{8'h21, 8'h21, 8'h00, 8'h00};
        tbl[2] = '{8'h01, 8'h01, 8'h00, 8'h20};
        tbl[3] = '{8'h01, 8'h01, 8'h00, 8'h00};
        tbl[4] = '{8'h21, 8'h21, 8'h20, 8'h00};
        tbl[5] = '{8'h21, 8'h21, 8'h00, 8'h00};
        tbl[6] = '{8'hA1, 8'hA1, 8'h80, 8'h00};
        tbl[7] = '{8'h81, 8'h81, 8'h00, 8'h20};
        tbl[8] = '{8'h80, 8'h80, 8'h00, 8'h01};
        tbl[9] = '{8'h80, 8'h80, 8'h00, 8'h00};
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        io_reset        = 1'b0;
        io_pins_raw     = 8'hFF;
        io_cfg_prescale = 16'd0;
        io_cfg_bypass   = 1'b0;

        // Reset held with raw all-ones
        step(3);
        check("reset_filtered", io_pins_filtered, 8'h00);
        check("reset_rise", io_rise, 8'h00);
        check("reset_fall", io_fall, 8'h00);

        // Release: accept lands on the 6th edge with a single rise pulse
        io_reset = 1'b1;
        c = cyc;
        for (int k = 1; k <= 5; k++) expect_at(c + k, 8'h00, 8'h00, 8'h00, "rel_wait");
        expect_at(c + 6, 8'hFF, 8'hFF & EM, 8'h00, "rel_accept");
        expect_at(c + 7, 8'hFF, 8'h00, 8'h00, "rel_after");
        step(8);

        // All pins fall
        io_pins_raw = 8'h00;
        c = cyc;
        for (int k = 1; k <= 5; k++) expect_at(c + k, 8'hFF, 8'h00, 8'h00, "fall_wait");
        expect_at(c + 6, 8'h00, 8'h00, 8'hFF & EM, "fall_accept");
        expect_at(c + 7, 8'h00, 8'h00, 8'h00, "fall_after");
        step(8);

        // Pin 3 high for 3 cycles (rejected), pin 2 high for 4 cycles (accepted then released)
        io_pins_raw = 8'h0C;
        c = cyc;
        for (int k = 1; k <= 14; k++)
            expect_at(c + k, (k >= 6 && k <= 9) ? 8'h04 : 8'h00,
                      (k == 6) ? (8'h04 & EM) : 8'h00,
                      (k == 10) ? (8'h04 & EM) : 8'h00, "glitch");
        step(3);
        io_pins_raw = 8'h04;
        step(1);
        io_pins_raw = 8'h00;
        step(11);

        // Prescale 9: pin 0 step accepted within 33..42 cycles, one rise pulse
        io_cfg_prescale = 16'd9;
        io_pins_raw     = 8'h01;
        first = 0; nrise = 0; seen = 1'b0; rise_at_first = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step(1);
            if (!seen && io_pins_filtered[0]) begin
                seen = 1'b1;
                first = k;
                rise_at_first = io_rise[0];
            end
            if (io_rise[0]) nrise++;
        end
        n_cmp++;
        if (!(seen && first >= 33 && first <= 42)) begin
            n_bad++;
            $display("FAIL presc_latency: got %0d cycles (seen=%0d), required 33..42", first, seen);
        end
        check("presc_filtered", io_pins_filtered, 8'h01);
        check("presc_nrise", nrise, (EM != 8'h00) ? 1 : 0);
        check("presc_rise_aligned", rise_at_first, (EM != 8'h00) ? 1 : 0);
        io_cfg_prescale = 16'd0;
        step(2);

        // Bypass: 3-cycle latency, pulse on every change
        io_cfg_bypass = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            io_pins_raw = tbl[i].raw;
            expect_at(cyc + 3, tbl[i].f, tbl[i].r & EM, tbl[i].fl & EM, $sformatf("byp%0d", i));
        end
        step(4);

        // Leaving bypass with pins steady must not pulse
        io_cfg_bypass = 1'b0;
        c = cyc;
        for (int k = 1; k <= 8; k++) expect_at(c + k, 8'h80, 8'h00, 8'h00, "byp_exit");
        step(9);

        // Prescale 1000 -> 2 with count at 500
        io_cfg_prescale = 16'd1000;
        seen = 1'b0;
        for (int k = 0; k < 1100 && !seen; k++) begin
            step(1);
            #1;
            if (dut.w_tick) seen = 1'b1;
        end
        check("tick_1000_seen", seen, 1);
        nt = 0;
        for (int k = 0; k < 501; k++) begin
            step(1);
            #1;
            if (dut.w_tick) nt++;
        end
        check("tick_1000_quiet", nt, 0);
        io_cfg_prescale = 16'd2;
        #1;
        check("tick_immediate", dut.w_tick, 1);
        for (int j = 0; j < 6; j++) begin
            step(1);
            #1;
            check($sformatf("tick_p2_%0d", j), dut.w_tick, pat[j]);
        end
        io_cfg_prescale = 16'd0;

        // Reset mid-debounce discards partial counts; held pins accepted after release
        step(1);
        io_pins_raw = 8'h7F;
        step(3);
        io_reset = 1'b0;
        #1;
        check("midrst_filtered", io_pins_filtered, 8'h00);
        check("midrst_rise", io_rise, 8'h00);
        check("midrst_fall", io_fall, 8'h00);
        step(2);
        io_reset = 1'b1;
        c = cyc;
        for (int k = 1; k <= 5; k++) expect_at(c + k, 8'h00, 8'h00, 8'h00, "midrst_wait");
        expect_at(c + 6, 8'h7F, 8'h7F & EM, 8'h00, "midrst_accept");
        expect_at(c + 7, 8'h7F, 8'h00, 8'h00, "midrst_after");
        step(8);

        step(2);
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_input_filter.md
# gpio_input_filter

Per-pin input conditioner between the GPIO pad buffers' read outputs and the SoC `pins_read` inputs. It provides:
- two-flop synchronisation of each asynchronous pad input;
- a shared prescaled sample tick;
- per-pin debounce that accepts a new level only after it is stable for a programmable number of ticks;
- one-cycle rise/fall pulses on accepted level changes.

One instance serves the status bank and one serves the controller bank.

## Interface
Parameters:
- `WIDTH`, default 24: number of pins.
- `PRESCALE_W`, default 16: width of the prescaler counter and of `io_cfg_prescale`.
- `SAMPLES`, default 4, minimum 1: number of consecutive mismatching ticks required to accept a new level.

Ports:
- `io_clock`  input  1: sole clock, rising edge.
- `io_reset`  input  1: reset, asynchronous and active-low.
- `io_pins_raw`  input  WIDTH: pad read values, asynchronous to `io_clock`.
- `io_cfg_prescale`  input  PRESCALE_W: tick period minus one; 0 gives a tick every cycle.
- `io_cfg_bypass`  input  1: 1 passes the synchronised value straight through with no debounce.
- `io_pins_filtered`  output  WIDTH: debounced level, to SoC `pins_read`.
- `io_rise`  output  WIDTH: one-cycle pulse when a filtered bit goes 0→1.
- `io_fall`  output  WIDTH: one-cycle pulse when a filtered bit goes 1→0.

## Operation
- Reset (`io_reset`=0) clears the following to 0:
  - both sync stages;
  - the prescaler counter;
  - all per-pin counters;
  - `io_pins_filtered`, `io_rise` and `io_fall`.
- Synchroniser: `io_pins_raw` → ff1 → ff2. Only ff2 ("sync") is used downstream.
- Prescaler:
  - tick = (count ≥ `io_cfg_prescale`).
  - On tick, count resets to 0; otherwise it increments.
  - The ≥ compare means that lowering `io_cfg_prescale` mid-count gives a tick on the next cycle with no wrap-around.
- Per-pin debounce, evaluated only on cycles with tick=1:
  - sync == filtered: counter resets to 0.
  - sync != filtered and counter < `SAMPLES`-1: counter increments.
  - sync != filtered and counter == `SAMPLES`-1: filtered ← sync and counter ← 0. This is an "accept".
- Cycles with tick=0 hold both the counter and the filtered value.
- A glitch shorter than `SAMPLES` ticks never reaches the output, because any matching tick clears the counter.
- Bypass (`io_cfg_bypass`=1):
  - filtered ← sync every cycle;
  - all counters are held at 0;
  - the prescaler keeps running.
  - Leaving bypass produces no spurious edge, because filtered already equals sync.
- Edges: each accept (or a bypass change) registers `io_rise` = new & ~old and `io_fall` = ~new & old. These pulses go high in the same cycle the new filtered value appears and last exactly one cycle.
- Pins are fully independent. Simultaneous accepts on several pins produce simultaneous pulses.
- Asserting reset mid-debounce discards partial counts immediately. After release, filtered is 0, and a pin held at 1 is accepted after the normal latency, producing a rise pulse.

## Timing
- With prescale=0 and bypass=0, a raw change stable from before edge E1 works through the pipeline as follows:
  - ff1 on E1;
  - sync on E2;
  - counter increments on E3 … E(1+`SAMPLES`);
  - accept on E(2+`SAMPLES`).
- Total latency is therefore 2+`SAMPLES` cycles. With defaults that is 6 cycles.
- With prescale P: latency = 2 cycles plus the time to the `SAMPLES`th tick after sync changes. The worst case is 2 + `SAMPLES`·(P+1) cycles.
- Bypass latency is 3 cycles: ff1, ff2, filtered register.
- Every output is registered, so there is no combinational path from any input to any output.

## Configuration
- `GPIO_FILTER_EDGE_EN`:
  - Defined: edge registers are built and `io_rise`/`io_fall` behave as described above.
  - Undefined: the edge logic is not built and `io_rise`/`io_fall` are tied to constant 0. Filtering is unchanged.

## Structure
- Shared package `gpio_filter_pkg` holds:
  - default constants: `GPIO_FILTER_DEFAULT_SAMPLES` = 4 and `GPIO_FILTER_DEFAULT_PRESCALE_W` = 16;
  - a counter-width function of ⌈log2(`SAMPLES`)⌉, minimum 1.
- Sub-module `gpio_filter_pin` covers a single pin: sync flops, debounce counter, filtered bit and edge flops. It takes tick and bypass as inputs.
- The top level instantiates the prescaler once plus a generate array of `WIDTH` `gpio_filter_pin` instances.

## Test plan
- Reset hold with raw=all-ones, then release, prescale=0 → filtered=0 until cycle 6 after release; then filtered=all-ones, with `io_rise`=all-ones for exactly 1 cycle.
- Pin 3 glitch high for 3 cycles, prescale=0, `SAMPLES`=4 → filtered[3] stays 0 and no pulses are generated.
- Pin 0 steps 0→1 with prescale=9 → filtered[0] changes within 2+4·10=42 cycles and not before 2+3·10+1=33 cycles; a single `io_rise`[0] pulse accompanies it.
- Bypass=1 while pin 5 toggles every 2 cycles → filtered[5] follows raw with 3-cycle latency and produces a pulse on every change; deasserting bypass with the pin steady produces no pulse.
- Prescale changed from 1000 to 2 while the count is 500 → a tick occurs on the next cycle, then a tick every 3 cycles.
- Build without `GPIO_FILTER_EDGE_EN`, repeat the first scenario → filtered still changes at cycle 6, and `io_rise`/`io_fall` stay 0 throughout.
